// File: rtl/sfx_arbiter.sv
// sfx_arbiter: priority arbiter that picks which sound-effect track the player should play
module sfx_arbiter #(
    parameter int               N_EVT     = 4,
    parameter int               SEL_W     = 4,
    parameter logic [N_EVT-1:0] LOOP_MASK = 4'b1000,
    parameter int               RETRIG    = 1
) (
    input  logic             MCLK,
    input  logic             resetN,
    input  logic             onOff,
    input  logic [N_EVT-1:0] evt,
    input  logic             theme_ended,
    output logic [SEL_W-1:0] select,
    output logic             new_trackN,
    output logic             busy,
    output logic [7:0]       overrun_cnt
);
    typedef enum logic {IDLE, PLAY} state_t;
    state_t state, state_n;
    logic [SEL_W-1:0] cur, cur_n, select_n, win, gsel;
    logic [N_EVT-1:0] pend, pend_n, evt_q, cur_oh, rise, fresh, req, ovr, grant_oh;
    logic [7:0] cnt_n;
    logic new_trackN_n, blank_q, hi_req, cur_loop, shot_play, retrig, te_ok, grant, to_idle;

    // Request qualification, winner selection and next-state/output decision
    always_comb begin
        cur_oh = '0;
        win = '0;
        hi_req = 1'b0;
        grant_oh = '0;
        cnt_n = overrun_cnt;
        for (int i = 0; i < N_EVT; i++) cur_oh[i] = (cur == SEL_W'(i));
        cur_loop = |(cur_oh & LOOP_MASK);
        shot_play = (state == PLAY) && !cur_loop;
        rise = evt & ~evt_q & ~LOOP_MASK;
        fresh = rise & ~(shot_play ? cur_oh : '0);
        req = (evt & LOOP_MASK) | pend | fresh;
        ovr = fresh & pend;
        for (int i = N_EVT - 1; i >= 0; i--) if (req[i]) win = SEL_W'(i);
        for (int i = 0; i < N_EVT; i++) if (req[i] && SEL_W'(i) < cur) hi_req = 1'b1;
        retrig = shot_play && (RETRIG != 0) && |(rise & cur_oh);
        te_ok = theme_ended && new_trackN && !blank_q;
        grant = 1'b0;
        gsel = win;
        to_idle = 1'b0;
        if (state == IDLE) begin
            grant = |req;
        end else if (hi_req) begin
            grant = 1'b1;
        end else if (retrig) begin
            grant = 1'b1;
            gsel = cur;
        end else if (cur_loop && !(|(evt & cur_oh))) begin
            grant = |req;
            to_idle = ~|req;
        end else if (te_ok) begin
            grant = cur_loop || |req;
            gsel = cur_loop ? cur : win;
            to_idle = !cur_loop && ~|req;
        end
        for (int i = 0; i < N_EVT; i++) grant_oh[i] = grant && (gsel == SEL_W'(i));
        pend_n = (pend | fresh) & ~grant_oh;
        state_n = grant ? PLAY : (to_idle ? IDLE : state);
        cur_n = grant ? gsel : cur;
        select_n = grant ? gsel + SEL_W'(1) : (to_idle ? '0 : select);
        new_trackN_n = !grant;
        for (int i = 0; i < N_EVT; i++) if (ovr[i] && cnt_n != 8'hFF) cnt_n = cnt_n + 8'd1;
        if (!onOff) begin
            state_n = IDLE;
            cur_n = '0;
            select_n = '0;
            new_trackN_n = 1'b1;
            pend_n = '0;
            cnt_n = overrun_cnt;
        end
    end

    // State and registered outputs; stale theme_ended is masked for one cycle after each pulse
    always_ff @(posedge MCLK or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            cur <= '0;
            pend <= '0;
            evt_q <= '0;
            select <= '0;
            new_trackN <= 1'b1;
            busy <= 1'b0;
            blank_q <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            state <= state_n;
            cur <= cur_n;
            pend <= pend_n;
            evt_q <= evt;
            select <= select_n;
            new_trackN <= new_trackN_n;
            busy <= (state_n == PLAY);
            blank_q <= !new_trackN;
            overrun_cnt <= cnt_n;
        end
    end
endmodule
